bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that produces the packed 4-digit BCD word consumed by the multiplexed 7-segment display stage. It accepts an unsigned binary value on a start/busy/done handshake, saturates out-of-range values, and emits a leading-zero blank mask so the display can suppress unused digits. It sits between the value source (counter, sensor, arithmetic) and the per-digit nibble selector.

---
 rtl/bin_to_bcd_seq_pkg.sv | 20 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin_to_bcd_seq.sv | 127 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Decimal digits needed for a WIDTH-bit value: ceil(width * log10(2)), log10(2) ~ 0.30103.
    function automatic int scratch_digits(input int width);
        int d;
        d = (width * 30103 + 99999) / 100000;
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit corrector: a nibble of 5 or more gets +3 before the next left shift.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) adjusted = digit + 4'd3;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with saturation and leading-zero blank mask.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [WIDTH-1:0]              bin_in,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [DIGITS*BCD_DIGIT_W-1:0] bcd,
    output logic                          ovf,
    output logic [DIGITS-1:0]             blank
);

    localparam int SCRATCH_DIGITS = (scratch_digits(WIDTH) > DIGITS) ? scratch_digits(WIDTH) : DIGITS;
    localparam int SCRATCH_W      = SCRATCH_DIGITS * BCD_DIGIT_W;
    localparam int OUT_W          = DIGITS * BCD_DIGIT_W;
    localparam int CNT_W          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WIDTH - 1);
    localparam logic [OUT_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    state_t                 state;
    state_t                 next_state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WIDTH-1:0]       shift_reg;
    logic [SCRATCH_W-1:0]   scratch;
    logic [SCRATCH_W-1:0]   scratch_adj;
    logic [SCRATCH_W-1:0]   scratch_next;
    logic [OUT_W-1:0]       bcd_q;
    logic                   ovf_q;
    logic                   ovf_next;
    logic                   zero_above;
    logic [DIGITS-1:0]      blank_mask;

    genvar gi;
    generate
        for (gi = 0; gi < SCRATCH_DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .adjusted (scratch_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign scratch_next = (scratch_adj << 1) | SCRATCH_W'(shift_reg[WIDTH-1]);

    // Any nonzero digit above the displayed range means the value does not fit.
    always_comb begin
        ovf_next = 1'b0;
        for (int i = DIGITS; i < SCRATCH_DIGITS; i++) begin
            if (scratch_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0) ovf_next = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (bit_cnt == '0) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? SHIFT : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Results are captured on the final shift edge so they appear together with the done pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            scratch   <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    scratch   <= scratch_next;
                    bit_cnt   <= bit_cnt - 1'b1;
                    if (bit_cnt == '0) begin
                        bcd_q <= ovf_next ? ALL_NINES : scratch_next[OUT_W-1:0];
                        ovf_q <= ovf_next;
                    end
                end
                default: begin
                    if (start) begin
                        shift_reg <= bin_in;
                        scratch   <= '0;
                        bit_cnt   <= CNT_LOAD;
                    end
                end
            endcase
        end
    end

    always_comb begin
        blank_mask = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (bcd_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'h0);
            blank_mask[i] = zero_above;
        end
    end

    assign bcd   = bcd_q;
    assign ovf   = ovf_q;
    assign blank = blank_mask;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq at default size and at WIDTH=8/DIGITS=3.
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST, start;
    logic [13:0] bin_in;
    logic        busy, done, ovf;
    logic [15:0] bcd;
    logic [3:0]  blank;

    logic        RST8, start8;
    logic [7:0]  bin8;
    logic        busy8, done8, ovf8;
    logic [11:0] bcd8;
    logic [2:0]  blank8;

    exp_t sb[$];
    exp_t sb8[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 CLK = ~CLK;

    bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
        .CLK(CLK), .RST(RST), .bin_in(bin_in), .start(start),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .blank(blank)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .CLK(CLK), .RST(RST8), .bin_in(bin8), .start(start8),
        .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8), .blank(blank8)
    );

    // Reference: saturate, then split into decimal digits by division.
    function automatic exp_t model(input int value, input int digits);
        exp_t e;
        int   v, lim;
        logic zero;
        lim     = 10 ** digits - 1;
        e.bcd   = '0;
        e.blank = '0;
        e.ovf   = (value > lim);
        v       = e.ovf ? lim : value;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        zero = 1'b1;
        for (int i = digits - 1; i >= 1; i--) begin
            zero       = zero && (e.bcd[4*i +: 4] == 4'h0);
            e.blank[i] = zero;
        end
        return e;
    endfunction

    task automatic convert(input int value, output int lat, output bit timed_out, output logic busy_first);
        @(negedge CLK);
        bin_in = 14'(value);
        start  = 1'b1;
        sb.push_back(model(value, 4));
        lat = 0; timed_out = 1'b1; busy_first = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (i == 0) begin start = 1'b0; busy_first = busy; end
            if (done) begin lat = i + 1; timed_out = 1'b0; break; end
        end
    endtask

    task automatic convert8(input int value, output int lat, output bit timed_out);
        @(negedge CLK);
        bin8   = 8'(value);
        start8 = 1'b1;
        sb8.push_back(model(value, 3));
        lat = 0; timed_out = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            if (i == 0) start8 = 1'b0;
            if (done8) begin lat = i + 1; timed_out = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; RST8 = 1'b1; start = 1'b0; start8 = 1'b0; bin_in = '0; bin8 = '0;
        repeat (3) @(posedge CLK);
        #1;
        vectors++;
        if ({busy, done, ovf} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctl got %b expected 000", {busy, done, ovf});
        end
        vectors++;
        if (bcd !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_bcd got %h expected 0000", bcd);
        end
        vectors++;
        if (blank !== 4'b1110) begin
            miscompares++;
            $display("[TB] FAIL reset_blank got %b expected 1110", blank);
        end
        vectors++;
        if ({busy8, done8, blank8} !== 5'b00110) begin
            miscompares++;
            $display("[TB] FAIL reset_w8 got %b expected 00110", {busy8, done8, blank8});
        end
        @(negedge CLK);
        RST = 1'b0; RST8 = 1'b0;
    endtask

    task automatic test_directed();
        int   vals[7] = '{0, 1234, 7, 40, 9999, 10000, 16383};
        int   lat;
        bit   to;
        logic bf;
        exp_t e;
        foreach (vals[k]) begin
            convert(vals[k], lat, to, bf);
            e = sb.pop_front();
            vectors++;
            if (to || lat != 15 || bf !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL timing_%0d got lat=%0d busy1=%b busy_done=%b expected lat=15 busy1=1 busy_done=0",
                         vals[k], lat, bf, busy);
                continue;
            end
            vectors++;
            if (bcd !== e.bcd || ovf !== e.ovf || blank !== e.blank) begin
                miscompares++;
                $display("[TB] FAIL result_%0d got bcd=%h ovf=%b blank=%b expected bcd=%h ovf=%b blank=%b",
                         vals[k], bcd, ovf, blank, e.bcd, e.ovf, e.blank);
            end
        end
    endtask

    task automatic test_ignore_start();
        int   pulses = 0;
        int   first_lat = 0;
        exp_t e;
        @(negedge CLK);
        bin_in = 14'd100;
        start  = 1'b1;
        sb.push_back(model(100, 4));
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (i == 0) start = 1'b0;
            if (i == 4) begin bin_in = 14'd200; start = 1'b1; end
            if (i == 5) start = 1'b0;
            if (done) begin
                pulses++;
                if (first_lat == 0) first_lat = i + 1;
            end
        end
        e = sb.pop_front();
        vectors++;
        if (pulses != 1 || first_lat != 15) begin
            miscompares++;
            $display("[TB] FAIL ignore_pulses got pulses=%0d lat=%0d expected pulses=1 lat=15", pulses, first_lat);
        end
        vectors++;
        if (bcd !== e.bcd) begin
            miscompares++;
            $display("[TB] FAIL ignore_bcd got %h expected %h", bcd, e.bcd);
        end
    endtask

    task automatic test_back_to_back();
        int   first = 0;
        int   gap = 0;
        exp_t ea, eb;
        @(negedge CLK);
        bin_in = 14'd4321;
        start  = 1'b1;
        sb.push_back(model(4321, 4));
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (done) begin first = i + 1; break; end
        end
        ea = sb.pop_front();
        vectors++;
        if (first != 15 || bcd !== ea.bcd) begin
            miscompares++;
            $display("[TB] FAIL b2b_first got lat=%0d bcd=%h expected lat=15 bcd=%h", first, bcd, ea.bcd);
        end
        bin_in = 14'd56;
        sb.push_back(model(56, 4));
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (i == 0) start = 1'b0;
            if (i == 7) begin
                vectors++;
                if (bcd !== ea.bcd || busy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_hold got bcd=%h busy=%b expected bcd=%h busy=1", bcd, busy, ea.bcd);
                end
            end
            if (done) begin gap = i + 1; break; end
        end
        start = 1'b0;
        eb = sb.pop_front();
        vectors++;
        if (gap != 15 || bcd !== eb.bcd || blank !== eb.blank) begin
            miscompares++;
            $display("[TB] FAIL b2b_second got gap=%0d bcd=%h blank=%b expected gap=15 bcd=%h blank=%b",
                     gap, bcd, blank, eb.bcd, eb.blank);
        end
    endtask

    task automatic test_reset_abort();
        bit   seen = 1'b0;
        int   lat;
        bit   to;
        logic bf;
        exp_t e;
        @(negedge CLK);
        bin_in = 14'd5555;
        start  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge CLK); #1;
            if (i == 0) start = 1'b0;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        vectors++;
        if ({busy, done, ovf} !== 3'b000 || bcd !== 16'h0000 || blank !== 4'b1110) begin
            miscompares++;
            $display("[TB] FAIL abort_state got busy=%b done=%b ovf=%b bcd=%h blank=%b expected 0 0 0 0000 1110",
                     busy, done, ovf, bcd, blank);
        end
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (done) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("[TB] FAIL abort_done got done=1 expected done=0");
        end
        convert(321, lat, to, bf);
        e = sb.pop_front();
        vectors++;
        if (to || lat != 15 || bcd !== e.bcd || blank !== e.blank) begin
            miscompares++;
            $display("[TB] FAIL abort_next got lat=%0d bcd=%h blank=%b expected lat=15 bcd=%h blank=%b",
                     lat, bcd, blank, e.bcd, e.blank);
        end
    endtask

    task automatic test_random();
        int   v, lat;
        bit   to;
        logic bf;
        exp_t e;
        for (int k = 0; k < 12; k++) begin
            v = int'($urandom_range(16383, 0));
            convert(v, lat, to, bf);
            e = sb.pop_front();
            vectors++;
            if (to || bcd !== e.bcd || ovf !== e.ovf || blank !== e.blank) begin
                miscompares++;
                $display("[TB] FAIL random_%0d got to=%b bcd=%h ovf=%b blank=%b expected bcd=%h ovf=%b blank=%b",
                         v, to, bcd, ovf, blank, e.bcd, e.ovf, e.blank);
            end
        end
    endtask

    task automatic test_width8();
        int   vals[4] = '{255, 0, 99, 100};
        int   lat;
        bit   to;
        exp_t e;
        foreach (vals[k]) begin
            convert8(vals[k], lat, to);
            e = sb8.pop_front();
            vectors++;
            if (to || lat != 9 || bcd8 !== e.bcd[11:0] || ovf8 !== e.ovf || blank8 !== e.blank[2:0]) begin
                miscompares++;
                $display("[TB] FAIL w8_%0d got lat=%0d bcd=%h ovf=%b blank=%b expected lat=9 bcd=%h ovf=%b blank=%b",
                         vals[k], lat, bcd8, ovf8, blank8, e.bcd[11:0], e.ovf, e.blank[2:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_width8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
